// File: rtl/ocbench_pkg.sv
// Shared definitions for the on-chip bench run sequencer: register map,
// control/status bit positions, FSM states and the byte-lane merge helper.
package ocbench_pkg;

  localparam int CNT_W = 10;
  localparam logic [CNT_W-1:0] COUNT_MAX = 10'd512;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_COUNT  = 2'd1;
  localparam logic [1:0] REG_LAT    = 2'd2;
  localparam logic [1:0] REG_CYCLES = 2'd3;

  localparam int CTRL_START = 0;
  localparam int CTRL_ABORT = 1;
  localparam int STAT_BUSY  = 0;
  localparam int STAT_DONE  = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  function automatic logic [31:0] be_merge(input logic [31:0] old_v,
                                           input logic [31:0] new_v,
                                           input logic [3:0]  be);
    logic [31:0] res;
    res = old_v;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) begin
        res[8*i +: 8] = new_v[8*i +: 8];
      end else begin
        res[8*i +: 8] = old_v[8*i +: 8];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/ocbench_sequencer_if.sv
// Host Avalon-MM slave port plus the TX/RX memory address/enable outputs.
interface ocbench_sequencer_if #(
  parameter int ADDR_W = 9
) ();

  logic [8:0]        AVALON_ADDRESS;
  logic              AVALON_CHIPSELECT;
  logic              AVALON_WRITE;
  logic              AVALON_READ;
  logic [3:0]        AVALON_BYTEENABLE;
  logic [31:0]       AVALON_WRITEDATA;
  logic [31:0]       AVALON_READDATA;
  logic [ADDR_W-1:0] TX_MEMADDR;
  logic              TX_VALID;
  logic [ADDR_W-1:0] RX_MEMADDR;
  logic              RX_WREN;

  modport master (
    output AVALON_ADDRESS, AVALON_CHIPSELECT, AVALON_WRITE, AVALON_READ,
           AVALON_BYTEENABLE, AVALON_WRITEDATA,
    input  AVALON_READDATA, TX_MEMADDR, TX_VALID, RX_MEMADDR, RX_WREN
  );

  modport slave (
    input  AVALON_ADDRESS, AVALON_CHIPSELECT, AVALON_WRITE, AVALON_READ,
           AVALON_BYTEENABLE, AVALON_WRITEDATA,
    output AVALON_READDATA, TX_MEMADDR, TX_VALID, RX_MEMADDR, RX_WREN
  );

endinterface

// File: rtl/ocbench_delayline.sv
// Programmable-depth {valid, addr} shift line; tap lat_i selects the delay,
// lat_i == 0 passes the input straight through.
module ocbench_delayline #(
  parameter int ADDR_W = 9,
  parameter int LAT_W  = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic [LAT_W-1:0]  lat_i,
  input  logic              valid_i,
  input  logic [ADDR_W-1:0] addr_i,
  output logic              valid_o,
  output logic [ADDR_W-1:0] addr_o
);

  localparam int DEPTH = (1 << LAT_W) - 1;

  logic [DEPTH:1]    valid_q;
  logic [ADDR_W-1:0] addr_q [DEPTH:1];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= '0;
      for (int i = 1; i <= DEPTH; i++) begin
        addr_q[i] <= '0;
      end
    end else if (flush_i) begin
      valid_q <= '0;
      for (int i = 1; i <= DEPTH; i++) begin
        addr_q[i] <= '0;
      end
    end else begin
      valid_q <= {valid_q[DEPTH-1:1], valid_i};
      addr_q[1] <= addr_i;
      for (int i = 2; i <= DEPTH; i++) begin
        addr_q[i] <= addr_q[i-1];
      end
    end
  end

  always_comb begin
    valid_o = valid_i;
    addr_o  = addr_i;
    if (lat_i != '0) begin
      valid_o = valid_q[lat_i];
      addr_o  = addr_q[lat_i];
    end else begin
      valid_o = valid_i;
      addr_o  = addr_i;
    end
  end

endmodule

// File: rtl/ocbench_sequencer.sv
// Run sequencer: Avalon-MM register file, TX address generator FSM and the
// latency-delayed RX write address/enable path.
module ocbench_sequencer
  import ocbench_pkg::*;
#(
  parameter int ADDR_W = 9,
  parameter int LAT_W  = 4
) (
  input  logic CLK,
  input  logic RESET,
  ocbench_sequencer_if.slave bus
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] tx_addr_q, tx_addr_d;
  logic              tx_valid_q, tx_valid_d;
  logic [LAT_W-1:0]  drain_q, drain_d;
  logic              done_q, done_d;
  logic [31:0]       cycles_q, cycles_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [LAT_W-1:0]  lat_q, lat_d;
  logic [31:0]       readdata_q, readdata_d;

  logic              busy_s;
  logic              wr_s;
  logic [1:0]        sel_s;
  logic              ctrl_wr_s;
  logic              start_s;
  logic              abort_s;
  logic              flush_s;
  logic [31:0]       cnt_merge_s;
  logic              rx_wren_s;
  logic [ADDR_W-1:0] rx_addr_s;
  logic              unused_s;

  assign busy_s      = (state_q != IDLE);
  assign wr_s        = bus.AVALON_CHIPSELECT & bus.AVALON_WRITE;
  assign sel_s       = bus.AVALON_ADDRESS[1:0];
  assign ctrl_wr_s   = wr_s & (sel_s == REG_CTRL) & bus.AVALON_BYTEENABLE[0];
  assign start_s     = ctrl_wr_s & bus.AVALON_WRITEDATA[CTRL_START];
  assign abort_s     = ctrl_wr_s & bus.AVALON_WRITEDATA[CTRL_ABORT];
  assign cnt_merge_s = be_merge(32'(count_q), bus.AVALON_WRITEDATA, bus.AVALON_BYTEENABLE);
  assign unused_s    = ^bus.AVALON_ADDRESS[8:2];

  always_comb begin
    state_d    = state_q;
    tx_addr_d  = tx_addr_q;
    tx_valid_d = tx_valid_q;
    drain_d    = drain_q;
    done_d     = done_q;
    cycles_d   = cycles_q;
    count_d    = count_q;
    lat_d      = lat_q;
    flush_s    = 1'b0;

    if (busy_s) begin
      cycles_d = (cycles_q == 32'hFFFF_FFFF) ? cycles_q : cycles_q + 32'd1;
    end else begin
      cycles_d = cycles_q;
    end

    if (wr_s && (sel_s == REG_COUNT) && !busy_s) begin
      count_d = (cnt_merge_s > 32'(COUNT_MAX)) ? COUNT_MAX : cnt_merge_s[CNT_W-1:0];
    end else begin
      count_d = count_q;
    end

    // A latency change retargets the tap onto stale history, so the line is emptied.
    if (wr_s && (sel_s == REG_LAT) && !busy_s && bus.AVALON_BYTEENABLE[0]) begin
      lat_d   = bus.AVALON_WRITEDATA[LAT_W-1:0];
      flush_s = 1'b1;
    end else begin
      lat_d = lat_q;
    end

    case (state_q)
      IDLE: begin
        if (start_s && !abort_s) begin
          if (count_q != '0) begin
            state_d    = RUN;
            tx_valid_d = 1'b1;
            tx_addr_d  = '0;
            done_d     = 1'b0;
            cycles_d   = 32'd0;
          end else begin
            done_d = 1'b1;
          end
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (CNT_W'(tx_addr_q) == count_q - CNT_W'(1)) begin
          tx_valid_d = 1'b0;
          tx_addr_d  = '0;
          drain_d    = '0;
          if (lat_q == '0) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = DRAIN;
          end
        end else begin
          tx_addr_d = tx_addr_q + ADDR_W'(1);
        end
      end
      DRAIN: begin
        // The last RX write issues in the LATENCY-th drain cycle.
        if (drain_q == lat_q - LAT_W'(1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          drain_d = drain_q + LAT_W'(1);
        end
      end
      default: begin
        state_d    = IDLE;
        tx_valid_d = 1'b0;
        tx_addr_d  = '0;
      end
    endcase

    if (abort_s) begin
      state_d    = IDLE;
      tx_valid_d = 1'b0;
      tx_addr_d  = '0;
      drain_d    = '0;
      done_d     = done_q;
      flush_s    = 1'b1;
    end else begin
      flush_s = flush_s;
    end
  end

  always_comb begin
    readdata_d = readdata_q;
    if (bus.AVALON_CHIPSELECT && bus.AVALON_READ) begin
      case (sel_s)
        REG_CTRL:   readdata_d = {30'd0, done_q, busy_s};
        REG_COUNT:  readdata_d = 32'(count_q);
        REG_LAT:    readdata_d = 32'(lat_q);
        REG_CYCLES: readdata_d = cycles_q;
        default:    readdata_d = 32'd0;
      endcase
    end else begin
      readdata_d = readdata_q;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q    <= IDLE;
      tx_addr_q  <= '0;
      tx_valid_q <= 1'b0;
      drain_q    <= '0;
      done_q     <= 1'b0;
      cycles_q   <= 32'd0;
      count_q    <= '0;
      lat_q      <= '0;
      readdata_q <= 32'd0;
    end else begin
      state_q    <= state_d;
      tx_addr_q  <= tx_addr_d;
      tx_valid_q <= tx_valid_d;
      drain_q    <= drain_d;
      done_q     <= done_d;
      cycles_q   <= cycles_d;
      count_q    <= count_d;
      lat_q      <= lat_d;
      readdata_q <= readdata_d;
    end
  end

  ocbench_delayline #(
    .ADDR_W (ADDR_W),
    .LAT_W  (LAT_W)
  ) u_delayline (
    .clk_i   (CLK),
    .rst_i   (RESET),
    .flush_i (flush_s),
    .lat_i   (lat_q),
    .valid_i (tx_valid_q),
    .addr_i  (tx_addr_q),
    .valid_o (rx_wren_s),
    .addr_o  (rx_addr_s)
  );

  assign bus.AVALON_READDATA = readdata_q;
  assign bus.TX_MEMADDR      = tx_addr_q;
  assign bus.TX_VALID        = tx_valid_q;
  assign bus.RX_MEMADDR      = rx_addr_s;
  assign bus.RX_WREN         = rx_wren_s;

endmodule

// File: tb/tb_ocbench_sequencer.sv
// Scoreboard bench for ocbench_sequencer: a run-level reference model queues
// expected TX/RX/readback events; a negedge monitor pops and compares them.
module tb_ocbench_sequencer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ocbench_sequencer_if #(.ADDR_W(9)) bus ();

  ocbench_sequencer #(.ADDR_W(9), .LAT_W(4)) dut (
    .CLK   (clk),
    .RESET (rst),
    .bus   (bus)
  );

  typedef struct {
    int cyc;
    int val;
    int tag;
  } ev_t;

  ev_t txq[$];
  ev_t rxq[$];
  ev_t rdq[$];
  ev_t e;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  int count_m;
  int lat_m;
  int m_t;
  int m_end;
  bit m_done;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  task automatic flag(input string name, input int val);
    checks++;
    errors++;
    $display("FAIL %s @cycle %0d: value %0d", name, cyc, val);
  endtask

  // Monitor: compare every presented TX/RX event and every read return.
  always @(negedge clk) begin
    if (!rst) begin
      while (txq.size() > 0 && txq[0].cyc < cyc) begin
        e = txq.pop_front();
        flag("tx_missing_addr", e.val);
      end
      if (bus.TX_VALID) begin
        if (txq.size() > 0 && txq[0].cyc == cyc) begin
          e = txq.pop_front();
          chk("tx_addr", 32'(bus.TX_MEMADDR), 32'(e.val));
        end else begin
          flag("tx_unexpected_addr", int'(bus.TX_MEMADDR));
        end
      end else begin
        chk("tx_idle_addr", 32'(bus.TX_MEMADDR), 32'd0);
      end
      while (rxq.size() > 0 && rxq[0].cyc < cyc) begin
        e = rxq.pop_front();
        flag("rx_missing_addr", e.val);
      end
      if (bus.RX_WREN) begin
        if (rxq.size() > 0 && rxq[0].cyc == cyc) begin
          e = rxq.pop_front();
          chk("rx_addr", 32'(bus.RX_MEMADDR), 32'(e.val));
        end else begin
          flag("rx_unexpected_addr", int'(bus.RX_MEMADDR));
        end
      end
      if (rdq.size() > 0 && rdq[0].cyc == cyc) begin
        e = rdq.pop_front();
        chk($sformatf("readdata_reg%0d", e.tag), bus.AVALON_READDATA, 32'(e.val));
      end
    end
  end

  function automatic bit m_busy(input int r);
    return (r > m_t) && (r < m_end);
  endfunction

  function automatic int exp_reg(input int r, input int at);
    int v;
    case (r)
      0: v = m_busy(at) ? 1 : (m_done ? 2 : 0);
      1: v = count_m;
      2: v = lat_m;
      default: v = m_busy(at) ? (at - m_t - 1) : (m_end - m_t - 1);
    endcase
    return v;
  endfunction

  task automatic model_reset();
    count_m = 0;
    lat_m   = 0;
    m_t     = cyc;
    m_end   = cyc + 1;
    m_done  = 1'b0;
    txq.delete();
    rxq.delete();
    rdq.delete();
  endtask

  task automatic model_write(input int r, input logic [31:0] d, input logic [3:0] be, input int w);
    ev_t keep[$];
    longint mask;
    longint merged;
    bit busy;
    busy = m_busy(w);
    if (r == 0 && be[0]) begin
      if (d[1]) begin
        if (busy) begin
          m_end  = w + 1;
          m_done = 1'b0;
          keep.delete();
          foreach (txq[i]) if (txq[i].cyc <= w) keep.push_back(txq[i]);
          txq = keep;
          keep.delete();
          foreach (rxq[i]) if (rxq[i].cyc <= w) keep.push_back(rxq[i]);
          rxq = keep;
        end
      end else if (d[0] && !busy) begin
        m_done = 1'b1;
        if (count_m != 0) begin
          m_t   = w;
          m_end = w + count_m + lat_m + 1;
          for (int i = 0; i < count_m; i++) begin
            txq.push_back('{w + 1 + i, i, 0});
            rxq.push_back('{w + 1 + lat_m + i, i, 0});
          end
        end
      end
    end else if (r == 1 && !busy) begin
      mask = 0;
      for (int k = 0; k < 4; k++) if (be[k]) mask += longint'(255) << (8 * k);
      merged = (longint'(count_m) & ~mask) | (longint'(d) & mask);
      count_m = (merged > 512) ? 512 : int'(merged);
    end else if (r == 2 && !busy && be[0]) begin
      lat_m = int'(d) & 15;
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic av_write(input int r, input logic [31:0] d, input logic [3:0] be);
    model_write(r, d, be, cyc);
    bus.AVALON_ADDRESS    = {7'($urandom), 2'(r)};
    bus.AVALON_CHIPSELECT = 1'b1;
    bus.AVALON_WRITE      = 1'b1;
    bus.AVALON_BYTEENABLE = be;
    bus.AVALON_WRITEDATA  = d;
    step(1);
    bus.AVALON_CHIPSELECT = 1'b0;
    bus.AVALON_WRITE      = 1'b0;
  endtask

  task automatic av_read(input int r);
    rdq.push_back('{cyc + 1, exp_reg(r, cyc), r});
    bus.AVALON_ADDRESS    = {7'($urandom), 2'(r)};
    bus.AVALON_CHIPSELECT = 1'b1;
    bus.AVALON_READ       = 1'b1;
    step(1);
    bus.AVALON_CHIPSELECT = 1'b0;
    bus.AVALON_READ       = 1'b0;
  endtask

  task automatic wait_idle();
    while (cyc < m_end + 1) step(1);
    step(2);
  endtask

  task automatic read_all();
    av_read(0);
    av_read(1);
    av_read(2);
    av_read(3);
  endtask

  task automatic do_start(input int c, input int l);
    av_write(1, 32'(c), 4'hF);
    av_write(2, 32'(l), 4'h1);
    av_write(0, 32'd1, 4'h1);
  endtask

  initial begin
    int ta;
    rst = 1'b1;
    bus.AVALON_ADDRESS    = 9'd0;
    bus.AVALON_CHIPSELECT = 1'b0;
    bus.AVALON_WRITE      = 1'b0;
    bus.AVALON_READ       = 1'b0;
    bus.AVALON_BYTEENABLE = 4'h0;
    bus.AVALON_WRITEDATA  = 32'd0;
    step(3);
    chk("reset_tx_valid", 32'(bus.TX_VALID), 32'd0);
    chk("reset_tx_addr", 32'(bus.TX_MEMADDR), 32'd0);
    chk("reset_rx_wren", 32'(bus.RX_WREN), 32'd0);
    chk("reset_readdata", bus.AVALON_READDATA, 32'd0);
    rst = 1'b0;
    model_reset();
    step(1);
    read_all();

    // COUNT=4 LATENCY=2: RX lags by two, CYCLES=6.
    do_start(4, 2);
    wait_idle();
    read_all();

    // COUNT=1 LATENCY=0: TX and RX coincide.
    do_start(1, 0);
    wait_idle();
    read_all();

    // COUNT write of 1000 clamps to 512; full-depth latency.
    av_write(1, 32'd1000, 4'hF);
    av_read(1);
    av_write(2, 32'd15, 4'h1);
    av_write(0, 32'd1, 4'h1);
    wait_idle();
    read_all();

    // ABORT five cycles after START.
    av_write(1, 32'd8, 4'hF);
    av_write(2, 32'd3, 4'h1);
    ta = cyc + 5;
    av_write(0, 32'd1, 4'h1);
    while (cyc < ta) step(1);
    av_write(0, 32'd2, 4'h1);
    wait_idle();
    read_all();

    // START with COUNT=0 sets done next cycle with no memory activity.
    av_write(1, 32'd0, 4'hF);
    av_write(0, 32'd1, 4'h1);
    av_read(0);
    step(3);

    // START and ABORT together: nothing happens.
    av_write(1, 32'd5, 4'hF);
    av_write(0, 32'd3, 4'h1);
    step(10);
    read_all();

    // START and COUNT writes while busy are ignored.
    do_start(6, 2);
    av_write(0, 32'd1, 4'h1);
    av_write(1, 32'd3, 4'hF);
    av_read(0);
    wait_idle();
    read_all();

    for (int it = 0; it < 25; it++) begin
      logic [31:0] d;
      logic [3:0]  be;
      d  = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 40));
      be = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'hF;
      av_write(1, d, be);
      av_write(2, $urandom, 4'($urandom_range(0, 15)));
      av_write(0, 32'd1, 4'h1);
      step($urandom_range(0, 4));
      av_read(3);
      av_read(0);
      if ($urandom_range(0, 2) == 0) begin
        ta = cyc + $urandom_range(0, count_m + lat_m + 1);
        while (cyc < ta) step(1);
        av_write(0, 32'd2, 4'h1);
      end
      wait_idle();
      read_all();
    end

    // Asynchronous reset in the middle of a run.
    do_start(20, 5);
    step(5);
    #2;
    rst = 1'b1;
    txq.delete();
    rxq.delete();
    rdq.delete();
    #1;
    chk("midrun_reset_tx_valid", 32'(bus.TX_VALID), 32'd0);
    chk("midrun_reset_tx_addr", 32'(bus.TX_MEMADDR), 32'd0);
    chk("midrun_reset_rx_wren", 32'(bus.RX_WREN), 32'd0);
    chk("midrun_reset_rx_addr", 32'(bus.RX_MEMADDR), 32'd0);
    chk("midrun_reset_readdata", bus.AVALON_READDATA, 32'd0);
    step(2);
    rst = 1'b0;
    model_reset();
    step(1);
    read_all();
    step(3);

    chk("tx_queue_drained", 32'(txq.size()), 32'd0);
    chk("rx_queue_drained", 32'(rxq.size()), 32'd0);
    chk("rd_queue_drained", 32'(rdq.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ocbench_sequencer.md
# ocbench_sequencer

Run sequencer for the on-chip bench. It holds a small Avalon-MM register file that software uses to program a run, then streams vector addresses into the TX vector memory and generates write addresses and enables for the RX result memory. The RX side lags the TX side by a programmable pipeline latency. It sits between the host Avalon fabric and the avalonmem_tx / avalonmem_rx pair, on the memory clock.

## Interface
- ADDR_W, 9, TX/RX memory address width (memory depth 2^ADDR_W).
- LAT_W, 4, latency field width; maximum latency is 2^LAT_W-1.
- CLK  in  1  memory/control clock; all logic is on this one clock.
- RESET  in  1  asynchronous, active-high reset.
- AVALON_ADDRESS  in  9  register word address; bits [1:0] decoded, upper bits ignored.
- AVALON_CHIPSELECT  in  1  slave select.
- AVALON_WRITE  in  1  write strobe, qualified by CHIPSELECT.
- AVALON_READ  in  1  read strobe, qualified by CHIPSELECT.
- AVALON_BYTEENABLE  in  4  write byte lanes.
- AVALON_WRITEDATA  in  32  write data.
- AVALON_READDATA  out  32  registered read data.
- TX_MEMADDR  out  ADDR_W  TX memory read address.
- TX_VALID  out  1  TX_MEMADDR carries a live vector this cycle.
- RX_MEMADDR  out  ADDR_W  RX memory write address.
- RX_WREN  out  1  RX memory write enable.

## Operation
- Register map:
  - 0 CTRL/STATUS. Write bit0=START, bit1=ABORT (byte lane 0). Read returns bit0=busy, bit1=done.
  - 1 COUNT, bits[9:0], vectors per run. Writes of values >512 clamp to 512. Reset value 0.
  - 2 LATENCY, bits[LAT_W-1:0]. Reset value 0.
  - 3 CYCLES, 32-bit, read-only. Busy cycles of the last run; saturates at 0xFFFFFFFF.
- Writes honour BYTEENABLE per lane. Writes to COUNT and LATENCY while busy are ignored.
- FSM states:
  - IDLE -> RUN on START with COUNT≠0. This clears done and CYCLES.
  - START with COUNT=0 moves IDLE -> IDLE with done=1 and no memory activity.
  - RUN: TX_VALID=1 and TX_MEMADDR counts 0..COUNT-1, one per cycle. After the last address the FSM moves to DRAIN; if LATENCY=0 it goes straight to IDLE.
  - DRAIN: no TX activity. The FSM waits until the last RX write has issued, then returns to IDLE and sets done.
- RX path: a delay line of depth LATENCY carrying {valid, addr}.
  - RX_WREN(t) = TX_VALID(t-LATENCY).
  - RX_MEMADDR(t) = TX_MEMADDR(t-LATENCY).
  - LATENCY=0 passes the TX signals straight through.
- ABORT in any state returns the FSM to IDLE the next cycle and flushes the delay line. RX_WREN is 0 from the next cycle, and done stays 0.
- START while busy is ignored. If START and ABORT are written together, ABORT wins.
- done is sticky until the next START.
- busy = (state≠IDLE).
- CYCLES increments every cycle while busy.

## Timing
- Reset values: all outputs 0; state IDLE; COUNT=0, LATENCY=0, CYCLES=0, done=0.
- RESET asserted mid-run clears all outputs immediately, asynchronously.
- START written in cycle t: TX_VALID is high in cycles t+1 .. t+COUNT.
- RX_WREN is high in cycles t+1+LATENCY .. t+COUNT+LATENCY.
- done and busy=0 are visible from cycle t+COUNT+LATENCY+1.
- CYCLES equals COUNT+LATENCY for a complete run.
- Read latency is 1: READDATA is valid the cycle after CHIPSELECT&READ and holds otherwise. No waitrequest.
- COUNT=512 issues addresses 0..511. TX_MEMADDR returns to 0 in the cycle after the run ends, with TX_VALID=0.

## Structure
- Shared package ocbench_pkg holds:
  - register offsets (REG_CTRL=0, REG_COUNT=1, REG_LAT=2, REG_CYCLES=3);
  - CTRL bit indices;
  - the FSM state enum (IDLE, RUN, DRAIN).
- One sub-module, ocbench_delayline: a programmable-depth {valid, addr} shift line with a synchronous flush, depth 2^LAT_W-1, tap selected by LATENCY.

## Test plan
- Reset: assert RESET mid-run -> all outputs 0 immediately; register reads return 0.
- COUNT=4, LATENCY=2, START at t -> TX_MEMADDR 0,1,2,3 in t+1..t+4; RX_WREN with addresses 0..3 in t+3..t+6; done at t+7; CYCLES=6.
- COUNT=1, LATENCY=0 -> TX_VALID and RX_WREN both high in t+1 with address 0; done at t+2; CYCLES=1.
- COUNT write 1000 reads back 512; run with LATENCY=15 -> last TX address 511 at t+512; last RX_WREN at t+527; no address wrap while valid; CYCLES=527.
- COUNT=8, LATENCY=3, ABORT at t+5 -> TX_VALID and RX_WREN 0 from t+6; busy=0; done=0; no further RX writes.
- START while busy, COUNT write while busy -> both ignored; START with COUNT=0 -> done=1 next cycle with zero TX/RX activity.
